z80_clk_sequencer: RTL and testbench
====================================

Name: z80_clk_sequencer

Overview:
- Control FSM that sequences the Z80 clock divider.
- Drives the divider's 1-cycle start and reset strobes and counts divided-clock rising edges using the divider's rose pulse.
- Runs the power-on and on-demand CPU reset hold, free-run, single-step and N-cycle burst modes.
- Sits between the debug/UART command logic and the divider; also owns the CPU reset line.

Parameters:
RESET_CYCLES, 4, number of divided-clock rising edges CPU reset is held low (must be >=1)
RUN_AFTER_RESET, 0, 1: go straight to RUN after reset hold; 0: stop divider and go IDLE
BURST_WIDTH, 8, width of burst length / remaining counter
COUNT_WIDTH, 16, width of executed-cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_run_stb  in  1  start free-running clock
i_stop_stb  in  1  stop clock
i_step_stb  in  1  run exactly one divided cycle
i_burst_stb  in  1  run i_burst_len divided cycles
i_burst_len  in  BURST_WIDTH  burst length, sampled with i_burst_stb
i_cpu_reset_stb  in  1  request CPU reset hold sequence
i_div_clk_rose  in  1  divider rising-edge pulse
o_div_start_stb  out  1  1-cycle start strobe to divider
o_div_reset_stb  out  1  1-cycle stop/reset strobe to divider
o_cpu_reset_n  out  1  Z80 reset, active low
o_done_stb  out  1  1-cycle pulse: burst/step completed
o_busy  out  1  state != IDLE
o_state  out  2  IDLE=0, RESET_HOLD=1, RUN=2, BURST=3
o_cycle_count  out  COUNT_WIDTH  divided rising edges since last CPU reset release, wraps

Behaviour:
- All outputs registered.
- Async reset values: state IDLE, o_cpu_reset_n=0, all strobes 0, o_busy=0, o_cycle_count=0, remaining=0, por_pending=1.
- Strobe handling: all input strobes are 1 cycle. Outputs appear 1 cycle after the causing input.
- Priority within a cycle: i_cpu_reset_stb > i_stop_stb > i_run_stb > i_burst_stb > i_step_stb.
- POR: on the first clock after i_reset deasserts with por_pending=1:
  - go RESET_HOLD, pulse o_div_start_stb, clear por_pending.
  - Input strobes in that cycle are ignored.
- IDLE:
  - i_run_stb -> RUN, pulse o_div_start_stb.
  - i_burst_stb with len>0 -> BURST, remaining=len, pulse start.
  - i_burst_stb with len=0 -> stay IDLE, pulse o_done_stb, no start.
  - i_step_stb is identical to a burst with len=1.
  - i_cpu_reset_stb -> RESET_HOLD, pulse start, o_cpu_reset_n<=0.
  - i_stop_stb ignored.
- RESET_HOLD:
  - o_cpu_reset_n=0; hold counter loaded with RESET_CYCLES on entry; each i_div_clk_rose decrements it.
  - On the rose that makes it 0: o_cpu_reset_n<=1, o_cycle_count<=0.
  - That rose then goes RUN if RUN_AFTER_RESET=1 (no strobe), else pulses o_div_reset_stb and goes IDLE.
  - i_stop_stb, i_run_stb, i_burst_stb and i_step_stb are ignored here.
  - i_cpu_reset_stb reloads the hold counter.
- RUN:
  - i_stop_stb -> pulse o_div_reset_stb, go IDLE, no done.
  - i_cpu_reset_stb -> RESET_HOLD without restarting the divider (divider keeps running), o_cpu_reset_n<=0.
  - run, step and burst strobes ignored.
- BURST:
  - Each rose decrements remaining. The rose with remaining==1 pulses o_div_reset_stb and o_done_stb, and goes IDLE.
  - i_run_stb -> RUN (divider untouched).
  - i_stop_stb -> abort: reset strobe, IDLE, no done.
  - i_cpu_reset_stb behaves as in RUN.
  - step/burst ignored.
- Final rose and i_stop_stb in the same cycle: burst counts as complete, o_done_stb=1, single o_div_reset_stb.
- o_cycle_count:
  - +1 on each i_div_clk_rose while in RUN or BURST with o_cpu_reset_n=1. The rose that ends a burst or coincides with stop is counted.
  - Wraps from all-ones to 0. Frozen in IDLE.
- o_div_start_stb and o_div_reset_stb are never asserted in the same cycle. Neither is asserted on consecutive cycles.
- i_reset mid-operation: immediate return to reset values. The POR sequence reruns after release.

Test Plan:
- Release i_reset, feed a rose every 20 cycles -> o_div_start_stb 1 cycle after release; o_cpu_reset_n rises and o_div_reset_stb pulses on the cycle after the 4th rose; state IDLE, count 0.
- IDLE, i_burst_stb len=3 -> start pulse; after 3rd rose: o_done_stb + o_div_reset_stb same cycle, o_cycle_count=3, state IDLE.
- IDLE, i_step_stb, then i_burst_stb len=0 -> one cycle executed with done; second strobe gives immediate o_done_stb, no start, count unchanged.
- RUN for 10 roses, then i_stop_stb -> o_div_reset_stb next cycle, no o_done_stb, count=10; later roses do not change count.
- BURST len=5, after 2 roses i_cpu_reset_stb -> o_cpu_reset_n=0, no divider strobes, 4 more roses -> release, count=0. Repeat with RUN_AFTER_RESET=1 -> state RUN, no reset strobe.
- Start count at 16'hFFFE in RUN, 3 roses -> count 16'h0001; assert i_reset mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/z80_clk_sequencer.sv
// Control FSM for the Z80 clock divider: power-on / on-demand CPU reset hold,
// free-run, single-step and N-cycle burst, plus an executed-cycle counter.
module z80_clk_sequencer #(
  parameter int RESET_CYCLES    = 4,
  parameter int RUN_AFTER_RESET = 0,
  parameter int BURST_WIDTH     = 8,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_run_stb,
  input  logic                   i_stop_stb,
  input  logic                   i_step_stb,
  input  logic                   i_burst_stb,
  input  logic [BURST_WIDTH-1:0] i_burst_len,
  input  logic                   i_cpu_reset_stb,
  input  logic                   i_div_clk_rose,
  output logic                   o_div_start_stb,
  output logic                   o_div_reset_stb,
  output logic                   o_cpu_reset_n,
  output logic                   o_done_stb,
  output logic                   o_busy,
  output logic [1:0]             o_state,
  output logic [COUNT_WIDTH-1:0] o_cycle_count
);

  localparam int HOLD_WIDTH = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(RESET_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_BURST      = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic                   por_pending_r, por_pending_s;
  logic [HOLD_WIDTH-1:0]  hold_r, hold_s;
  logic [BURST_WIDTH-1:0] remaining_r, remaining_s;
  logic                   cpu_reset_n_r, cpu_reset_n_s;
  logic                   start_r, start_s;
  logic                   div_reset_r, div_reset_s;
  logic                   done_r, done_s;
  logic                   busy_r;
  logic [COUNT_WIDTH-1:0] count_r, count_s;
  logic                   last_rose_s;

  // Next-state, strobe and counter logic
  always_comb begin
    state_s       = state_r;
    por_pending_s = por_pending_r;
    hold_s        = hold_r;
    remaining_s   = remaining_r;
    cpu_reset_n_s = cpu_reset_n_r;
    start_s       = 1'b0;
    div_reset_s   = 1'b0;
    done_s        = 1'b0;
    last_rose_s   = i_div_clk_rose && (remaining_r <= BURST_WIDTH'(1));

    if (i_div_clk_rose && cpu_reset_n_r && ((state_r == ST_RUN) || (state_r == ST_BURST))) begin
      count_s = count_r + COUNT_WIDTH'(1);
    end else begin
      count_s = count_r;
    end

    if (por_pending_r) begin
      // First clock after reset: all command strobes are dropped
      state_s       = ST_RESET_HOLD;
      start_s       = 1'b1;
      por_pending_s = 1'b0;
      hold_s        = HOLD_LOAD;
      cpu_reset_n_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_cpu_reset_stb) begin
            state_s       = ST_RESET_HOLD;
            start_s       = 1'b1;
            hold_s        = HOLD_LOAD;
            cpu_reset_n_s = 1'b0;
          end else if (i_stop_stb) begin
            state_s = ST_IDLE;
          end else if (i_run_stb) begin
            state_s = ST_RUN;
            start_s = 1'b1;
          end else if (i_burst_stb) begin
            if (i_burst_len != '0) begin
              state_s     = ST_BURST;
              remaining_s = i_burst_len;
              start_s     = 1'b1;
            end else begin
              done_s = 1'b1;
            end
          end else if (i_step_stb) begin
            state_s     = ST_BURST;
            remaining_s = BURST_WIDTH'(1);
            start_s     = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RESET_HOLD: begin
          if (i_cpu_reset_stb) begin
            hold_s = HOLD_LOAD;
          end else if (i_div_clk_rose) begin
            if (hold_r <= HOLD_WIDTH'(1)) begin
              hold_s        = '0;
              cpu_reset_n_s = 1'b1;
              count_s       = '0;
              if (RUN_AFTER_RESET != 0) begin
                state_s = ST_RUN;
              end else begin
                state_s     = ST_IDLE;
                div_reset_s = 1'b1;
              end
            end else begin
              hold_s = hold_r - HOLD_WIDTH'(1);
            end
          end else begin
            hold_s = hold_r;
          end
        end
        ST_RUN: begin
          // CPU reset from RUN leaves the divider running
          if (i_cpu_reset_stb) begin
            state_s       = ST_RESET_HOLD;
            hold_s        = HOLD_LOAD;
            cpu_reset_n_s = 1'b0;
          end else if (i_stop_stb) begin
            state_s     = ST_IDLE;
            div_reset_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_BURST: begin
          if (i_cpu_reset_stb) begin
            state_s       = ST_RESET_HOLD;
            hold_s        = HOLD_LOAD;
            cpu_reset_n_s = 1'b0;
            remaining_s   = '0;
          end else if (i_stop_stb) begin
            // A stop landing on the final rose still completes the burst
            state_s     = ST_IDLE;
            div_reset_s = 1'b1;
            done_s      = last_rose_s;
            remaining_s = '0;
          end else if (i_run_stb) begin
            state_s     = ST_RUN;
            remaining_s = '0;
          end else if (last_rose_s) begin
            state_s     = ST_IDLE;
            div_reset_s = 1'b1;
            done_s      = 1'b1;
            remaining_s = '0;
          end else if (i_div_clk_rose) begin
            remaining_s = remaining_r - BURST_WIDTH'(1);
          end else begin
            remaining_s = remaining_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      por_pending_r <= 1'b1;
      hold_r        <= '0;
      remaining_r   <= '0;
      cpu_reset_n_r <= 1'b0;
      start_r       <= 1'b0;
      div_reset_r   <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      count_r       <= '0;
    end else begin
      state_r       <= state_s;
      por_pending_r <= por_pending_s;
      hold_r        <= hold_s;
      remaining_r   <= remaining_s;
      cpu_reset_n_r <= cpu_reset_n_s;
      start_r       <= start_s;
      div_reset_r   <= div_reset_s;
      done_r        <= done_s;
      busy_r        <= (state_s != ST_IDLE);
      count_r       <= count_s;
    end
  end

  assign o_div_start_stb = start_r;
  assign o_div_reset_stb = div_reset_r;
  assign o_cpu_reset_n   = cpu_reset_n_r;
  assign o_done_stb      = done_r;
  assign o_busy          = busy_r;
  assign o_state         = state_r;
  assign o_cycle_count   = count_r;

endmodule

// File: tb/tb_z80_clk_sequencer.sv
// Directed bench for z80_clk_sequencer: a default instance plus a
// RUN_AFTER_RESET=1 instance driven by its own command strobes.
module tb_z80_clk_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_stb, stop_stb, step_stb, burst_stb, cpu_reset_stb, rose;
  logic [7:0]  burst_len;
  logic        start, div_rst, cpu_n, done, busy;
  logic [1:0]  state;
  logic [15:0] count;

  logic        b_cpu_reset_stb, b_rose;
  logic        b_start, b_div_rst, b_cpu_n, b_done, b_busy;
  logic [1:0]  b_state;
  logic [15:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z80_clk_sequencer dut (
    .i_clk(clk), .i_reset(rst),
    .i_run_stb(run_stb), .i_stop_stb(stop_stb), .i_step_stb(step_stb),
    .i_burst_stb(burst_stb), .i_burst_len(burst_len),
    .i_cpu_reset_stb(cpu_reset_stb), .i_div_clk_rose(rose),
    .o_div_start_stb(start), .o_div_reset_stb(div_rst), .o_cpu_reset_n(cpu_n),
    .o_done_stb(done), .o_busy(busy), .o_state(state), .o_cycle_count(count)
  );

  z80_clk_sequencer #(.RUN_AFTER_RESET(1)) dut_rar (
    .i_clk(clk), .i_reset(rst),
    .i_run_stb(1'b0), .i_stop_stb(1'b0), .i_step_stb(1'b0),
    .i_burst_stb(1'b0), .i_burst_len(8'd0),
    .i_cpu_reset_stb(b_cpu_reset_stb), .i_div_clk_rose(b_rose),
    .o_div_start_stb(b_start), .o_div_reset_stb(b_div_rst), .o_cpu_reset_n(b_cpu_n),
    .o_done_stb(b_done), .o_busy(b_busy), .o_state(b_state), .o_cycle_count(b_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set before this call are seen at the posedge, then cleared
  task automatic tick();
    @(negedge clk);
    run_stb = 1'b0; stop_stb = 1'b0; step_stb = 1'b0; burst_stb = 1'b0;
    cpu_reset_stb = 1'b0; rose = 1'b0; b_cpu_reset_stb = 1'b0; b_rose = 1'b0;
  endtask

  task automatic roses(input int n);
    for (int i = 0; i < n; i++) begin
      rose = 1'b1;
      tick();
    end
  endtask

  task automatic b_roses(input int n);
    for (int i = 0; i < n; i++) begin
      b_rose = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; burst_len = 8'd0;
    run_stb = 1'b0; stop_stb = 1'b0; step_stb = 1'b0; burst_stb = 1'b0;
    cpu_reset_stb = 1'b0; rose = 1'b0; b_cpu_reset_stb = 1'b0; b_rose = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_cpu_n", 32'(cpu_n), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", 32'({start, div_rst, done}), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);

    // Power-on sequence, rose every 20 cycles
    rst = 1'b0;
    run_stb = 1'b1;
    tick();
    check_val("por_start", 32'(start), 32'd1);
    check_val("por_state", 32'(state), 32'd1);
    check_val("por_cpu_n", 32'(cpu_n), 32'd0);
    check_val("por_busy", 32'(busy), 32'd1);
    check_val("rar_por_start", 32'(b_start), 32'd1);
    tick();
    check_val("por_start_once", 32'(start), 32'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (19) tick();
      rose = 1'b1;
      tick();
      if (k == 2) check_val("por_hold_3", 32'(cpu_n), 32'd0);
    end
    check_val("por_cpu_n_rel", 32'(cpu_n), 32'd1);
    check_val("por_div_rst", 32'(div_rst), 32'd1);
    check_val("por_idle", 32'(state), 32'd0);
    check_val("por_count", 32'(count), 32'd0);
    check_val("por_busy_end", 32'(busy), 32'd0);
    tick();
    check_val("por_div_rst_once", 32'(div_rst), 32'd0);

    // RUN_AFTER_RESET=1 instance: release goes to RUN without reset strobe
    b_roses(4);
    check_val("rar_state", 32'(b_state), 32'd2);
    check_val("rar_cpu_n", 32'(b_cpu_n), 32'd1);
    check_val("rar_no_div_rst", 32'(b_div_rst), 32'd0);
    b_roses(1);
    check_val("rar_count1", 32'(b_count), 32'd1);
    b_cpu_reset_stb = 1'b1;
    tick();
    check_val("rar_hold_state", 32'(b_state), 32'd1);
    check_val("rar_hold_cpu_n", 32'(b_cpu_n), 32'd0);
    check_val("rar_hold_strobes", 32'({b_start, b_div_rst}), 32'd0);
    b_roses(4);
    check_val("rar_rel_state", 32'(b_state), 32'd2);
    check_val("rar_rel_strobes", 32'({b_start, b_div_rst}), 32'd0);
    check_val("rar_rel_count", 32'(b_count), 32'd0);

    // Burst of 3
    burst_stb = 1'b1; burst_len = 8'd3;
    tick();
    check_val("b3_start", 32'(start), 32'd1);
    check_val("b3_state", 32'(state), 32'd3);
    roses(2);
    check_val("b3_no_done", 32'(done), 32'd0);
    roses(1);
    check_val("b3_done_rst", 32'({done, div_rst}), 32'd3);
    check_val("b3_count", 32'(count), 32'd3);
    check_val("b3_idle", 32'(state), 32'd0);
    tick();

    // Step, then zero-length burst
    step_stb = 1'b1;
    tick();
    check_val("step_start", 32'(start), 32'd1);
    roses(1);
    check_val("step_done_rst", 32'({done, div_rst}), 32'd3);
    check_val("step_count", 32'(count), 32'd4);
    tick();
    burst_stb = 1'b1; burst_len = 8'd0;
    tick();
    check_val("b0_done", 32'(done), 32'd1);
    check_val("b0_no_start", 32'(start), 32'd0);
    check_val("b0_state", 32'(state), 32'd0);
    check_val("b0_count", 32'(count), 32'd4);
    tick();

    // Burst of 5 interrupted by CPU reset after 2 roses
    burst_stb = 1'b1; burst_len = 8'd5;
    tick();
    roses(2);
    check_val("b5_count2", 32'(count), 32'd6);
    cpu_reset_stb = 1'b1;
    tick();
    check_val("b5_hold_cpu_n", 32'(cpu_n), 32'd0);
    check_val("b5_hold_strobes", 32'({start, div_rst, done}), 32'd0);
    check_val("b5_hold_state", 32'(state), 32'd1);
    roses(3);
    check_val("b5_still_hold", 32'(cpu_n), 32'd0);
    roses(1);
    check_val("b5_rel_cpu_n", 32'(cpu_n), 32'd1);
    check_val("b5_rel_count", 32'(count), 32'd0);
    check_val("b5_rel_div_rst", 32'(div_rst), 32'd1);
    check_val("b5_rel_state", 32'(state), 32'd0);
    tick();

    // Free run for 10 roses, then stop
    run_stb = 1'b1;
    tick();
    check_val("run_start", 32'(start), 32'd1);
    check_val("run_state", 32'(state), 32'd2);
    roses(10);
    stop_stb = 1'b1;
    tick();
    check_val("stop_div_rst", 32'(div_rst), 32'd1);
    check_val("stop_no_done", 32'(done), 32'd0);
    check_val("stop_count", 32'(count), 32'd10);
    check_val("stop_state", 32'(state), 32'd0);
    roses(2);
    check_val("idle_frozen", 32'(count), 32'd10);

    // Counter wrap in RUN
    run_stb = 1'b1;
    tick();
    roses(65524);
    check_val("wrap_fffe", 32'(count), 32'h0000_FFFE);
    roses(3);
    check_val("wrap_0001", 32'(count), 32'h0000_0001);
    check_val("wrap_state", 32'(state), 32'd2);

    // Asynchronous reset mid-RUN
    #2 rst = 1'b1;
    #1;
    check_val("arst_state", 32'(state), 32'd0);
    check_val("arst_cpu_n", 32'(cpu_n), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_count", 32'(count), 32'd0);
    check_val("arst_strobes", 32'({start, div_rst, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_val("repor_start", 32'(start), 32'd1);
    check_val("repor_state", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
